// File: rtl/ycr_memory_tb_ahb_mport.sv
// N-port AHB-Lite slave memory model: one shared word array, per-port wait states,
// an address ERROR window, and byte-lane writes with port-ordered merging.
`timescale 1ns/1ps
module ycr_memory_tb_ahb_mport #(
  parameter int          N_PORTS  = 2,
  parameter int          MEM_PWR  = 20,
  parameter logic [31:0] ERR_BASE = 32'hFFFF_0000,
  parameter logic [31:0] ERR_SIZE = 32'h0000_0100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [8*N_PORTS-1:0]  stall_cfg,
  input  logic [2*N_PORTS-1:0]  htrans,
  input  logic [3*N_PORTS-1:0]  hsize,
  input  logic [32*N_PORTS-1:0] haddr,
  input  logic [N_PORTS-1:0]    hwrite,
  input  logic [32*N_PORTS-1:0] hwdata,
  output logic [N_PORTS-1:0]    hready,
  output logic [32*N_PORTS-1:0] hrdata,
  output logic [N_PORTS-1:0]    hresp
);
  localparam int IW    = MEM_PWR - 2;
  localparam int WORDS = 2 ** IW;

  typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_e;

  logic [31:0] mem [WORDS];

  state_e             state_q [N_PORTS];
  state_e             state_d [N_PORTS];
  logic [7:0]         cnt_q   [N_PORTS];
  logic [7:0]         cnt_d   [N_PORTS];
  logic [IW-1:0]      idx_q   [N_PORTS];
  logic [IW-1:0]      idx_d   [N_PORTS];
  logic [3:0]         lanes_q [N_PORTS];
  logic [3:0]         lanes_d [N_PORTS];
  logic [31:0]        hrdata_q [N_PORTS];
  logic [31:0]        hrdata_d [N_PORTS];
  logic [N_PORTS-1:0] wr_q, wr_d, err_q, err_d, cmp_q, cmp_d;
  logic [N_PORTS-1:0] hready_q, hready_d, hresp_q, hresp_d;

  logic [N_PORTS-1:0] acc, bad;
  logic [3:0]         new_lanes [N_PORTS];
  logic [IW-1:0]      new_idx   [N_PORTS];
  logic [IW-1:0]      rd_idx    [N_PORTS];
  logic [31:0]        rd_word   [N_PORTS];
  logic               unused_htrans_lsb;

  function automatic logic in_err_window(input logic [31:0] a);
    return (ERR_SIZE != 32'd0) && (a >= ERR_BASE) && ((a - ERR_BASE) < ERR_SIZE);
  endfunction

  // Address-phase decode: acceptance, target word, byte lanes and error classification.
  always_comb begin
    unused_htrans_lsb = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      unused_htrans_lsb = unused_htrans_lsb ^ htrans[2*p];
      acc[p]     = hready_q[p] & htrans[2*p+1];
      new_idx[p] = haddr[32*p+2 +: IW];
      case (hsize[3*p +: 3])
        3'd0:    new_lanes[p] = 4'b0001 << haddr[32*p +: 2];
        3'd1:    new_lanes[p] = 4'b0011 << {haddr[32*p+1], 1'b0};
        default: new_lanes[p] = 4'b1111;
      endcase
      bad[p] = (hsize[3*p +: 3] > 3'd2)
            || (hsize[3*p +: 3] == 3'd1 && haddr[32*p])
            || (hsize[3*p +: 3] == 3'd2 && haddr[32*p +: 2] != 2'b00)
            || in_err_window(haddr[32*p +: 32]);
    end
  end

  // Read word seen at the loading edge includes writes committing on that same edge.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      rd_idx[p]  = (state_q[p] == WAIT) ? idx_q[p] : new_idx[p];
      rd_word[p] = mem[rd_idx[p]];
      for (int q = 0; q < N_PORTS; q++) begin
        if (cmp_q[q] && wr_q[q] && idx_q[q] == rd_idx[p]) begin
          for (int b = 0; b < 4; b++) begin
            if (lanes_q[q][b]) rd_word[p][8*b +: 8] = hwdata[32*q+8*b +: 8];
          end
        end
      end
    end
  end

  // NOTE: every _d is given its hold value before the case so no path can infer a latch.
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      state_d[p]  = state_q[p];
      cnt_d[p]    = cnt_q[p];
      idx_d[p]    = idx_q[p];
      lanes_d[p]  = lanes_q[p];
      wr_d[p]     = wr_q[p];
      err_d[p]    = err_q[p];
      cmp_d[p]    = 1'b0;
      hready_d[p] = hready_q[p];
      hresp_d[p]  = hresp_q[p];
      hrdata_d[p] = hrdata_q[p];
      case (state_q[p])
        WAIT: begin
          cnt_d[p] = cnt_q[p] - 8'd1;
          if (cnt_q[p] == 8'd1) begin
            if (err_q[p]) begin
              state_d[p] = ERR1;
              hresp_d[p] = 1'b1;
              if (!wr_q[p]) hrdata_d[p] = 32'd0;
            end else begin
              state_d[p]  = IDLE;
              hready_d[p] = 1'b1;
              cmp_d[p]    = 1'b1;
              if (!wr_q[p]) hrdata_d[p] = rd_word[p];
            end
          end
        end
        ERR1: begin
          state_d[p]  = ERR2;
          hready_d[p] = 1'b1;
          hresp_d[p]  = 1'b1;
        end
        default: begin
          state_d[p]  = IDLE;
          hready_d[p] = 1'b1;
          hresp_d[p]  = 1'b0;
          if (acc[p]) begin
            idx_d[p]   = new_idx[p];
            lanes_d[p] = new_lanes[p];
            wr_d[p]    = hwrite[p];
            err_d[p]   = bad[p];
            cnt_d[p]   = stall_cfg[8*p +: 8];
            if (stall_cfg[8*p +: 8] != 8'd0) begin
              state_d[p]  = WAIT;
              hready_d[p] = 1'b0;
            end else if (bad[p]) begin
              state_d[p]  = ERR1;
              hready_d[p] = 1'b0;
              hresp_d[p]  = 1'b1;
              if (!hwrite[p]) hrdata_d[p] = 32'd0;
            end else begin
              cmp_d[p] = 1'b1;
              if (!hwrite[p]) hrdata_d[p] = rd_word[p];
            end
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all ports update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < N_PORTS; p++) begin
        state_q[p]  <= IDLE;
        cnt_q[p]    <= 8'd0;
        idx_q[p]    <= '0;
        lanes_q[p]  <= 4'd0;
        hrdata_q[p] <= 32'd0;
      end
      wr_q     <= '0;
      err_q    <= '0;
      cmp_q    <= '0;
      hready_q <= '1;
      hresp_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      lanes_q  <= lanes_d;
      hrdata_q <= hrdata_d;
      wr_q     <= wr_d;
      err_q    <= err_d;
      cmp_q    <= cmp_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
    end
  end

  // NOTE: the array is deliberately not reset; preloaded images must survive rst_n.
  // Ports are applied in index order, so the highest port wins any shared byte lane.
  always_ff @(posedge clk) begin
    for (int q = 0; q < N_PORTS; q++) begin
      if (cmp_q[q] && wr_q[q]) begin
        for (int b = 0; b < 4; b++) begin
          if (lanes_q[q][b]) mem[idx_q[q]][8*b +: 8] <= hwdata[32*q+8*b +: 8];
        end
      end
    end
  end

  assign hready = hready_q;
  assign hresp  = hresp_q;
  always_comb begin
    for (int p = 0; p < N_PORTS; p++) hrdata[32*p +: 32] = hrdata_q[p];
  end

endmodule

// File: tb/tb_ycr_memory_tb_ahb_mport.sv
// Scoreboard bench for the two-port AHB-Lite memory model: drivers queue expected
// responses, a bus monitor pops and compares them when each data phase completes.
`timescale 1ns/1ps
module tb_ycr_memory_tb_ahb_mport;
  localparam int NP = 2;

  typedef struct {
    logic        err;
    int          waits;
    logic        chk;
    logic [31:0] data;
    int          tag;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [8*NP-1:0]  stall_cfg;
  logic [2*NP-1:0]  htrans;
  logic [3*NP-1:0]  hsize;
  logic [32*NP-1:0] haddr;
  logic [NP-1:0]    hwrite;
  logic [32*NP-1:0] hwdata;
  logic [NP-1:0]    hready;
  logic [32*NP-1:0] hrdata;
  logic [NP-1:0]    hresp;

  logic [1:0]  d_trans [NP];
  logic [2:0]  d_size  [NP];
  logic [31:0] d_addr  [NP];
  logic        d_write [NP];
  logic [31:0] d_wdata [NP];
  logic [7:0]  d_stall [NP];

  exp_t exp_q [NP][$];
  int   checks = 0;
  int   errors = 0;
  int   tag_n  = 0;

  logic pend   [NP];
  int   wait_c [NP];
  int   errc   [NP];

  ycr_memory_tb_ahb_mport #(.N_PORTS(NP), .MEM_PWR(20)) dut (
    .clk(clk), .rst_n(rst_n), .stall_cfg(stall_cfg), .htrans(htrans), .hsize(hsize),
    .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .hready(hready), .hrdata(hrdata),
    .hresp(hresp)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      htrans[2*p +: 2]    = d_trans[p];
      hsize[3*p +: 3]     = d_size[p];
      haddr[32*p +: 32]   = d_addr[p];
      hwrite[p]           = d_write[p];
      hwdata[32*p +: 32]  = d_wdata[p];
      stall_cfg[8*p +: 8] = d_stall[p];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // One AHB transfer: hold the address phase until accepted, then drive hwdata in the data phase.
  task automatic xfer(input int p, input logic wr, input logic [2:0] sz, input logic [31:0] a,
                      input logic [31:0] wd, input logic [7:0] st, input logic err,
                      input logic [31:0] rd, input logic push);
    int   n = 0;
    exp_t e;
    d_trans[p] = 2'b10;
    d_size[p]  = sz;
    d_addr[p]  = a;
    d_write[p] = wr;
    d_stall[p] = st;
    if (push) begin
      e.err   = err;
      e.waits = err ? int'(st) + 1 : int'(st);
      e.chk   = !wr;
      e.data  = rd;
      e.tag   = tag_n;
      tag_n++;
      exp_q[p].push_back(e);
    end
    @(negedge clk);
    while (!hready[p] && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) check($sformatf("p%0d_accept_timeout", p), {63'd0, hready[p]}, 64'd1);
    @(posedge clk);
    #1;
    d_trans[p] = 2'b00;
    d_stall[p] = 8'd0;
    d_wdata[p] = wd;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: tracks each accepted data phase and scores it when hready returns high.
  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < NP; p++) begin
      if (!rst_n) begin
        pend[p] = 1'b0;
      end else begin
        if (pend[p]) begin
          if (hready[p]) begin
            pend[p] = 1'b0;
            if (exp_q[p].size() == 0) begin
              check($sformatf("p%0d_unexpected_completion", p), 64'(exp_q[p].size()), 64'd1);
            end else begin
              e = exp_q[p].pop_front();
              check($sformatf("p%0d_t%0d_waits", p, e.tag), 64'(wait_c[p]), 64'(e.waits));
              check($sformatf("p%0d_t%0d_hresp", p, e.tag), {63'd0, hresp[p]}, {63'd0, e.err});
              check($sformatf("p%0d_t%0d_err1_cycles", p, e.tag), 64'(errc[p]), e.err ? 64'd1 : 64'd0);
              if (e.chk)
                check($sformatf("p%0d_t%0d_hrdata", p, e.tag), {32'd0, hrdata[32*p +: 32]}, {32'd0, e.data});
            end
          end else begin
            wait_c[p]++;
            if (hresp[p]) errc[p]++;
          end
        end
        if (hready[p] && d_trans[p][1]) begin
          pend[p]   = 1'b1;
          wait_c[p] = 0;
          errc[p]   = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    for (int p = 0; p < NP; p++) begin
      d_trans[p] = 2'b00; d_size[p] = 3'd2; d_addr[p] = 32'd0;
      d_write[p] = 1'b0;  d_wdata[p] = 32'd0; d_stall[p] = 8'd0;
      pend[p] = 1'b0; wait_c[p] = 0; errc[p] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hready", {62'd0, hready}, 64'd3);
    check("reset_hresp",  {62'd0, hresp},  64'd0);
    check("reset_hrdata", hrdata, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Zero-wait write then read-back on port 0.
    xfer(0, 1, 3'd2, 32'h100, 32'hDEAD_BEEF, 8'd0, 0, 32'h0, 1);
    xfer(0, 0, 3'd2, 32'h100, 32'h0, 8'd0, 0, 32'hDEAD_BEEF, 1);
    drain();

    // Port 1 stalled for 3 cycles while port 0 streams back-to-back reads.
    fork
      xfer(1, 0, 3'd2, 32'h100, 32'h0, 8'd3, 0, 32'hDEAD_BEEF, 1);
      begin
        xfer(0, 0, 3'd2, 32'h100, 32'h0, 8'd0, 0, 32'hDEAD_BEEF, 1);
        xfer(0, 0, 3'd2, 32'h100, 32'h0, 8'd0, 0, 32'hDEAD_BEEF, 1);
        xfer(0, 0, 3'd2, 32'h100, 32'h0, 8'd0, 0, 32'hDEAD_BEEF, 1);
      end
    join
    drain();

    // Byte and halfword lane writes.
    xfer(0, 1, 3'd0, 32'h102, 32'h0055_0000, 8'd0, 0, 32'h0, 1);
    xfer(0, 1, 3'd1, 32'h100, 32'h0000_AA11, 8'd1, 0, 32'h0, 1);
    xfer(0, 0, 3'd2, 32'h100, 32'h0, 8'd0, 0, 32'hDE55_AA11, 1);
    drain();

    // Error responses leave memory untouched; 0xFFFF_0010 aliases word 0xF0010.
    xfer(0, 1, 3'd2, 32'h0,       32'hCAFE_F00D, 8'd0, 0, 32'h0, 1);
    xfer(0, 1, 3'd2, 32'h000F_0010, 32'h1234_5678, 8'd0, 0, 32'h0, 1);
    xfer(0, 0, 3'd2, 32'h103,     32'h0, 8'd0, 1, 32'h0, 1);
    xfer(0, 0, 3'd2, 32'h103,     32'h0, 8'd2, 1, 32'h0, 1);
    xfer(0, 1, 3'd1, 32'hFFFF_0010, 32'hFFFF_FFFF, 8'd0, 1, 32'h0, 1);
    xfer(0, 1, 3'd3, 32'h0,       32'hFFFF_FFFF, 8'd0, 1, 32'h0, 1);
    xfer(0, 0, 3'd2, 32'h100,     32'h0, 8'd0, 0, 32'hDE55_AA11, 1);
    xfer(0, 0, 3'd2, 32'h0,       32'h0, 8'd0, 0, 32'hCAFE_F00D, 1);
    xfer(0, 0, 3'd2, 32'h000F_0010, 32'h0, 8'd0, 0, 32'h1234_5678, 1);
    drain();

    // Same-cycle writes from both ports: port 1 wins, then address wrap aliasing.
    fork
      xfer(0, 1, 3'd2, 32'h200, 32'h1111_1111, 8'd0, 0, 32'h0, 1);
      xfer(1, 1, 3'd2, 32'h200, 32'h2222_2222, 8'd0, 0, 32'h0, 1);
    join
    drain();
    xfer(0, 0, 3'd2, 32'h200,       32'h0, 8'd0, 0, 32'h2222_2222, 1);
    xfer(0, 1, 3'd2, 32'h0010_0200, 32'h3333_3333, 8'd0, 0, 32'h0, 1);
    xfer(0, 0, 3'd2, 32'h200,       32'h0, 8'd0, 0, 32'h3333_3333, 1);
    drain();

    // Non-overlapping same-cycle byte writes merge.
    fork
      xfer(0, 1, 3'd0, 32'h200, 32'h0000_00AA, 8'd0, 0, 32'h0, 1);
      xfer(1, 1, 3'd0, 32'h203, 32'hBB00_0000, 8'd0, 0, 32'h0, 1);
    join
    drain();

    // Same-cycle read (port 0) and write (port 1): read returns pre-write data.
    fork
      xfer(0, 0, 3'd2, 32'h200, 32'h0, 8'd0, 0, 32'hBB33_33AA, 1);
      xfer(1, 1, 3'd2, 32'h200, 32'h9999_9999, 8'd0, 0, 32'h0, 1);
    join
    drain();
    xfer(0, 0, 3'd2, 32'h200, 32'h0, 8'd0, 0, 32'h9999_9999, 1);
    drain();

    // Reset during stalled transfers: outputs return to reset values, write abandoned.
    fork
      xfer(0, 0, 3'd2, 32'h200, 32'h0, 8'd5, 0, 32'h0, 0);
      xfer(1, 1, 3'd2, 32'h200, 32'hFFFF_FFFF, 8'd5, 0, 32'h0, 0);
    join
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_hready", {62'd0, hready}, 64'd3);
    check("midrst_hresp",  {62'd0, hresp},  64'd0);
    check("midrst_hrdata", hrdata, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    fork
      xfer(0, 0, 3'd2, 32'h200, 32'h0, 8'd1, 0, 32'h9999_9999, 1);
      xfer(1, 0, 3'd2, 32'h100, 32'h0, 8'd0, 0, 32'hDE55_AA11, 1);
    join
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
